rotate_frame_scanner: RTL and testbench
=======================================

# rotate_frame_scanner

Frame-level sequencer placed directly upstream of the rotated-coordinate core. It walks every destination pixel of an `IMAGE_SIZE`×`IMAGE_SIZE` frame in raster order and issues one rotation request per pixel. For each result it reads the source pixel from image SRAM, or substitutes the background value when the rotated point is out of range. It then emits the pixel on a valid/ready stream toward the frame encoder.

## Interface
Parameters:
- `ANG_WIDTH`, 9, width of the signed angle in degrees (−180..180).
- `READ_LATENCY`, 1, SRAM read latency in cycles (fixed, ≥1).

Ports:
- `i_clk`  in  1  clock; one clock domain.
- `i_rst`  in  1  synchronous active-high reset.
- `i_start`  in  1  frame start pulse; ignored unless IDLE.
- `i_angle`  in  `ANG_WIDTH` signed  rotation angle; latched on the accepted `i_start`.
- `o_busy`  out  1  high from accepted start until the last pixel is accepted.
- `o_done`  out  1  one-cycle pulse after the last pixel is accepted.
- `o_rot_start`  out  1  one-cycle request pulse to the rotation core.
- `o_rot_H`, `o_rot_V`  out  `IMAGE_COOR_WIDTH`  destination coordinate sent to the rotation core.
- `o_rot_angle`  out  `ANG_WIDTH` signed  latched angle.
- `i_rot_H`, `i_rot_V`  in  `IMAGE_COOR_WIDTH`  rotated source coordinate.
- `i_rot_outOfRange`  in  1  rotated point lies outside the source image.
- `i_rot_valid`  in  1  rotation result valid.
- `o_sram_rd`  out  1  one-cycle read strobe.
- `o_sram_addr`  out  `IMAGE_ADDR_WIDTH`  source address.
- `i_sram_rdata`  in  `PIXEL_WIDTH`  read data.
- `o_pix_valid`  out  1  output pixel valid.
- `o_pix_H`, `o_pix_V`  out  `IMAGE_COOR_WIDTH`  destination coordinate of the output pixel.
- `o_pix_data`  out  `PIXEL_WIDTH`  pixel value.
- `i_pix_ready`  in  1  downstream accept.

## Operation
- FSM states: IDLE, LAUNCH, WAIT_ROT, READ, WAIT_READ, EMIT.
- **IDLE**
  - On `i_start`: latch `i_angle`, clear H/V counters to 0, assert `o_busy`, go to LAUNCH.
- **LAUNCH**
  - Pulse `o_rot_start` for one cycle, then go to WAIT_ROT.
  - `o_rot_H`/`o_rot_V` equal the counters and stay stable from LAUNCH until `i_rot_valid`.
- **WAIT_ROT**
  - Hold until `i_rot_valid`. The rotation core latency is variable and has no timeout.
  - On valid with `i_rot_outOfRange`=1: load `BACKGROUND_PIXEL` into the output register and go to EMIT. No SRAM read is issued.
  - On valid otherwise: register `i_rot_H`/`i_rot_V` and go to READ.
- **READ**
  - Pulse `o_sram_rd` with `o_sram_addr = rot_V*IMAGE_SIZE + rot_H`, computed unsigned in `IMAGE_ADDR_WIDTH` bits.
  - Go to WAIT_READ.
- **WAIT_READ**
  - Count `READ_LATENCY` cycles, capture `i_sram_rdata` on the last one, go to EMIT.
- **EMIT**
  - Hold `o_pix_valid`=1 with `o_pix_*` stable until `i_pix_ready`.
  - On accept, advance H. When H wraps from `IMAGE_SIZE−1` to 0, increment V.
  - After pixel (`IMAGE_SIZE−1`, `IMAGE_SIZE−1`): pulse `o_done`, drop `o_busy`, return to IDLE.
  - Otherwise go to LAUNCH.
- `i_rot_valid` outside WAIT_ROT is ignored.
- `i_start` while busy is ignored; the latched angle is unchanged.

## Timing
- Reset: every output is 0, FSM is IDLE, counters are 0, latched angle is 0.
- Reset wins over a same-cycle `i_start`.
- Reset mid-frame: outputs are 0 on the next cycle. Any pending rotation or read result is discarded.
- Per-pixel latency with ready held high:
  - In range: 1 (LAUNCH) + L_rot + 1 (READ) + `READ_LATENCY` + 1 (EMIT) cycles.
  - Out of range: 1 + L_rot + 1 cycles.
- `o_done` is asserted in the cycle after the final accept, in the same cycle `o_busy` falls.
- A new `i_start` is accepted from that cycle on.
- One rotation request is outstanding at a time; no pipelining across pixels.

## Structure
- Shared constants live in `sram_pkg`: `IMAGE_SIZE`, `IMAGE_COOR_WIDTH`, `IMAGE_ADDR_WIDTH`, `PIXEL_WIDTH`, `BACKGROUND_PIXEL`.
- The FSM state enum lives in `object_pkg` as `scan_state_t`.
- One sub-module, `raster_counter`: H/V counters with an `advance` input, wrap logic, and a `last` flag.

## Test plan
All scenarios use a behavioural rotation-core stub with programmable latency and an SRAM model preloaded with `mem[a]=a`.
- **Identity rotation:** angle 0, stub returns identity with latency 3.
  - Pixels are emitted in raster order with `o_pix_data = V*IMAGE_SIZE+H`.
  - Exactly `IMAGE_SIZE²` accepts, then a single `o_done`.
- **Out of range:** stub flags `i_rot_outOfRange` for destination (1,0).
  - That pixel carries `BACKGROUND_PIXEL`.
  - No `o_sram_rd` pulse occurs between its `o_rot_start` and its EMIT.
- **Backpressure:** `i_pix_ready` held low for 5 cycles on pixel (2,0).
  - `o_pix_*` stays stable and valid.
  - No new `o_rot_start` until the accept.
- **Start while busy:** angle 90 latched at start; `i_start` pulsed again with angle −45 mid-frame.
  - `o_rot_angle` stays 90 for the whole frame.
  - `o_busy` never drops early.
- **Reset during WAIT_ROT:** assert `i_rst` for one cycle while waiting, with the stub's `i_rot_valid` arriving one cycle after reset.
  - All outputs are 0 and the FSM is IDLE.
  - The late valid produces no read and no pixel.
- **Reset and start together:** `i_start` and `i_rst` in the same cycle.
  - Block remains IDLE with `o_busy`=0.
  - A start one cycle later begins at pixel (0,0).

Source files
------------

// File: rtl/rotate_frame_scanner_pkg.sv
// rtl/rotate_frame_scanner_pkg.sv - shared image constants and scanner state encoding
package sram_pkg;
  localparam int IMAGE_SIZE       = 4;
  localparam int IMAGE_COOR_WIDTH = 2;
  localparam int IMAGE_ADDR_WIDTH = 4;
  localparam int PIXEL_WIDTH      = 8;
  localparam logic [PIXEL_WIDTH-1:0] BACKGROUND_PIXEL = 8'hA5;

  // Row-major source address, wrapping inside IMAGE_ADDR_WIDTH bits.
  function automatic logic [IMAGE_ADDR_WIDTH-1:0] pixel_addr(
    input logic [IMAGE_COOR_WIDTH-1:0] h,
    input logic [IMAGE_COOR_WIDTH-1:0] v
  );
    return IMAGE_ADDR_WIDTH'(IMAGE_ADDR_WIDTH'(v) * IMAGE_ADDR_WIDTH'(IMAGE_SIZE))
         + IMAGE_ADDR_WIDTH'(h);
  endfunction
endpackage

package object_pkg;
  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    WAIT_ROT,
    READ,
    WAIT_READ,
    EMIT
  } scan_state_t;
endpackage

// File: rtl/rotate_frame_scanner_raster_counter.sv
// rtl/rotate_frame_scanner_raster_counter.sv - raster-order H/V destination counters
module raster_counter
  import sram_pkg::*;
(
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic                        i_clear,
  input  logic                        i_advance,
  output logic [IMAGE_COOR_WIDTH-1:0] o_h,
  output logic [IMAGE_COOR_WIDTH-1:0] o_v,
  output logic                        o_last
);
  localparam logic [IMAGE_COOR_WIDTH-1:0] COOR_MAX = IMAGE_COOR_WIDTH'(IMAGE_SIZE - 1);

  logic [IMAGE_COOR_WIDTH-1:0] h_q, h_d;
  logic [IMAGE_COOR_WIDTH-1:0] v_q, v_d;

  always_comb begin
    h_d = h_q;
    v_d = v_q;
    if (i_clear) begin
      h_d = '0;
      v_d = '0;
    end else if (i_advance) begin
      if (h_q == COOR_MAX) begin
        h_d = '0;
        v_d = (v_q == COOR_MAX) ? '0 : v_q + 1'b1;
      end else begin
        h_d = h_q + 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      h_q <= '0;
      v_q <= '0;
    end else begin
      h_q <= h_d;
      v_q <= v_d;
    end
  end

  assign o_h    = h_q;
  assign o_v    = v_q;
  assign o_last = (h_q == COOR_MAX) && (v_q == COOR_MAX);
endmodule

// File: rtl/rotate_frame_scanner.sv
// rtl/rotate_frame_scanner.sv - per-pixel rotation request, SRAM fetch and pixel stream emit
module rotate_frame_scanner
  import sram_pkg::*;
  import object_pkg::*;
#(
  parameter int ANG_WIDTH    = 9,
  parameter int READ_LATENCY = 1
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic                        i_start,
  input  logic signed [ANG_WIDTH-1:0] i_angle,
  output logic                        o_busy,
  output logic                        o_done,
  output logic                        o_rot_start,
  output logic [IMAGE_COOR_WIDTH-1:0] o_rot_H,
  output logic [IMAGE_COOR_WIDTH-1:0] o_rot_V,
  output logic signed [ANG_WIDTH-1:0] o_rot_angle,
  input  logic [IMAGE_COOR_WIDTH-1:0] i_rot_H,
  input  logic [IMAGE_COOR_WIDTH-1:0] i_rot_V,
  input  logic                        i_rot_outOfRange,
  input  logic                        i_rot_valid,
  output logic                        o_sram_rd,
  output logic [IMAGE_ADDR_WIDTH-1:0] o_sram_addr,
  input  logic [PIXEL_WIDTH-1:0]      i_sram_rdata,
  output logic                        o_pix_valid,
  output logic [IMAGE_COOR_WIDTH-1:0] o_pix_H,
  output logic [IMAGE_COOR_WIDTH-1:0] o_pix_V,
  output logic [PIXEL_WIDTH-1:0]      o_pix_data,
  input  logic                        i_pix_ready
);
  localparam int LAT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(READ_LATENCY - 1);

  scan_state_t                  state_q;
  logic signed [ANG_WIDTH-1:0]  angle_q;
  logic [IMAGE_COOR_WIDTH-1:0]  rot_h_q;
  logic [IMAGE_COOR_WIDTH-1:0]  rot_v_q;
  logic [PIXEL_WIDTH-1:0]       pix_data_q;
  logic [LAT_W-1:0]             lat_cnt_q;
  logic                         busy_q;
  logic                         done_q;
  logic                         rot_start_q;
  logic                         sram_rd_q;
  logic                         pix_valid_q;

  logic                         cnt_clear;
  logic                         cnt_advance;
  logic                         cnt_last;
  logic [IMAGE_COOR_WIDTH-1:0]  cnt_h;
  logic [IMAGE_COOR_WIDTH-1:0]  cnt_v;

  assign cnt_clear   = (state_q == IDLE) && i_start;
  assign cnt_advance = (state_q == EMIT) && i_pix_ready;

  raster_counter u_raster (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_clear   (cnt_clear),
    .i_advance (cnt_advance),
    .o_h       (cnt_h),
    .o_v       (cnt_v),
    .o_last    (cnt_last)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= IDLE;
      angle_q     <= '0;
      rot_h_q     <= '0;
      rot_v_q     <= '0;
      pix_data_q  <= '0;
      lat_cnt_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      rot_start_q <= 1'b0;
      sram_rd_q   <= 1'b0;
      pix_valid_q <= 1'b0;
    end else begin
      rot_start_q <= 1'b0;
      sram_rd_q   <= 1'b0;
      done_q      <= 1'b0;
      case (state_q)
        IDLE: begin
          if (i_start) begin
            angle_q     <= i_angle;
            busy_q      <= 1'b1;
            rot_start_q <= 1'b1;
            state_q     <= LAUNCH;
          end
        end
        LAUNCH: begin
          state_q <= WAIT_ROT;
        end
        WAIT_ROT: begin
          if (i_rot_valid) begin
            if (i_rot_outOfRange) begin
              pix_data_q  <= BACKGROUND_PIXEL;
              pix_valid_q <= 1'b1;
              state_q     <= EMIT;
            end else begin
              rot_h_q   <= i_rot_H;
              rot_v_q   <= i_rot_V;
              sram_rd_q <= 1'b1;
              state_q   <= READ;
            end
          end
        end
        READ: begin
          lat_cnt_q <= '0;
          state_q   <= WAIT_READ;
        end
        WAIT_READ: begin
          if (lat_cnt_q == LAT_LAST) begin
            pix_data_q  <= i_sram_rdata;
            pix_valid_q <= 1'b1;
            state_q     <= EMIT;
          end else begin
            lat_cnt_q <= lat_cnt_q + 1'b1;
          end
        end
        EMIT: begin
          if (i_pix_ready) begin
            pix_valid_q <= 1'b0;
            // The counter wraps to (0,0) on the final accept, ready for the next frame.
            if (cnt_last) begin
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= IDLE;
            end else begin
              rot_start_q <= 1'b1;
              state_q     <= LAUNCH;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_busy      = busy_q;
  assign o_done      = done_q;
  assign o_rot_start = rot_start_q;
  assign o_rot_H     = cnt_h;
  assign o_rot_V     = cnt_v;
  assign o_rot_angle = angle_q;
  assign o_sram_rd   = sram_rd_q;
  assign o_sram_addr = pixel_addr(rot_h_q, rot_v_q);
  assign o_pix_valid = pix_valid_q;
  assign o_pix_H     = cnt_h;
  assign o_pix_V     = cnt_v;
  assign o_pix_data  = pix_data_q;
endmodule

// File: tb/tb_rotate_frame_scanner.sv
// tb/tb_rotate_frame_scanner.sv - scoreboard bench for rotate_frame_scanner
module tb_rotate_frame_scanner;
  import sram_pkg::*;

  typedef struct packed {
    logic [1:0] h;
    logic [1:0] v;
    logic [7:0] d;
    logic       rd;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic signed [8:0] angle;
  logic              busy, done, rot_start;
  logic [1:0]        rot_h, rot_v;
  logic signed [8:0] rot_angle;
  logic [1:0]        rot_ih, rot_iv;
  logic              rot_oor, rot_valid;
  logic              sram_rd;
  logic [3:0]        sram_addr;
  logic [7:0]        sram_rdata = '0;
  logic              pix_valid;
  logic [1:0]        pix_h, pix_v;
  logic [7:0]        pix_data;
  logic              pix_ready;

  logic [7:0]        mem [16];
  exp_t              sb[$];
  int                total = 0;
  int                bad = 0;
  int                done_cnt = 0;
  int                accepts = 0;
  int                stall_cycles = 0;
  int                stub_lat;
  int                stub_cnt;
  int                bp_left;
  bit                bp_en, oor_en, frame_active, rd_seen, stalling;
  logic signed [8:0] exp_angle;
  logic [1:0]        req_h, req_v;
  logic [11:0]       snap;

  always #5 clk = ~clk;

  rotate_frame_scanner #(.ANG_WIDTH(9), .READ_LATENCY(1)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_angle(angle),
    .o_busy(busy), .o_done(done), .o_rot_start(rot_start),
    .o_rot_H(rot_h), .o_rot_V(rot_v), .o_rot_angle(rot_angle),
    .i_rot_H(rot_ih), .i_rot_V(rot_iv), .i_rot_outOfRange(rot_oor), .i_rot_valid(rot_valid),
    .o_sram_rd(sram_rd), .o_sram_addr(sram_addr), .i_sram_rdata(sram_rdata),
    .o_pix_valid(pix_valid), .o_pix_H(pix_h), .o_pix_V(pix_v), .o_pix_data(pix_data),
    .i_pix_ready(pix_ready)
  );

  initial for (int i = 0; i < 16; i++) mem[i] = 8'(i);

  always @(posedge clk) if (sram_rd) sram_rdata <= mem[sram_addr];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // identity rotation stub with programmable latency
  initial begin
    stub_cnt = 0; rot_valid = 0; rot_ih = 0; rot_iv = 0; rot_oor = 0; req_h = 0; req_v = 0;
    forever begin
      @(negedge clk);
      rot_valid = 0;
      if (stub_cnt > 0) begin
        stub_cnt--;
        if (stub_cnt == 0) begin
          rot_valid = 1; rot_ih = req_h; rot_iv = req_v;
          rot_oor = oor_en && req_h == 2'd1 && req_v == 2'd0;
        end
      end
      if (rot_start) begin
        stub_cnt = stub_lat; req_h = rot_h; req_v = rot_v;
      end
    end
  end

  initial begin
    pix_ready = 1;
    forever begin
      @(negedge clk);
      if (bp_en && pix_valid && pix_h == 2'd2 && pix_v == 2'd0 && bp_left > 0) begin
        pix_ready = 0; bp_left--;
      end else pix_ready = 1;
    end
  end

  // monitor: pops the scoreboard on every accepted pixel
  initial begin
    exp_t e;
    rd_seen = 0; stalling = 0;
    forever begin
      @(negedge clk); #1;
      if (!rst) begin
        if (rot_start) begin
          rd_seen = 0;
          check("rot_angle", rot_angle, exp_angle);
          check("busy_at_launch", busy, 1);
          check("launch_while_pending", pix_valid, 0);
          if (sb.size() > 0) check("rot_coord", {rot_h, rot_v}, {sb[0].h, sb[0].v});
        end
        if (sram_rd) rd_seen = 1;
        if (frame_active && !done) check("busy_held", busy, 1);
        if (pix_valid) begin
          if (pix_ready) begin
            if (sb.size() == 0) begin
              total++; bad++;
              $display("FAIL unexpected_pixel: got h=%0d v=%0d d=%0h expected none", pix_h, pix_v, pix_data);
            end else begin
              e = sb.pop_front();
              check("pixel", {pix_h, pix_v, pix_data, rd_seen}, e);
              if (bp_en && e.h == 2'd2 && e.v == 2'd0) check("stall_cycles", stall_cycles, 5);
              accepts++;
            end
            stalling = 0; stall_cycles = 0;
          end else begin
            if (!stalling) begin
              snap = {pix_h, pix_v, pix_data}; stalling = 1;
            end else check("stall_stable", {pix_h, pix_v, pix_data}, snap);
            stall_cycles++;
          end
        end
        if (done) begin
          done_cnt++;
          check("accepts_at_done", accepts, 16);
          check("busy_at_done", busy, 0);
          accepts = 0;
        end
      end
    end
  end

  task automatic run_frame(input logic signed [8:0] ang, input int lat, input bit oor,
                           input bit bp, input bit mid);
    exp_t e;
    int   t, d0;
    bit   mid_done;
    stub_lat = lat; oor_en = oor; bp_en = bp; bp_left = 5;
    for (int v = 0; v < 4; v++)
      for (int h = 0; h < 4; h++) begin
        e.h = 2'(h); e.v = 2'(v);
        if (oor && h == 1 && v == 0) begin e.d = BACKGROUND_PIXEL; e.rd = 0; end
        else begin e.d = 8'(v * 4 + h); e.rd = 1; end
        sb.push_back(e);
      end
    exp_angle = ang;
    d0 = done_cnt;
    @(negedge clk); angle = ang; start = 1;
    @(negedge clk); start = 0; frame_active = 1;
    t = 0; mid_done = 0;
    while (done_cnt == d0 && t < 3000) begin
      @(negedge clk); t++;
      start = 0;
      if (mid && !mid_done && accepts == 5) begin
        start = 1; angle = -9'sd45; mid_done = 1;
      end
    end
    frame_active = 0;
    if (done_cnt == d0) begin
      total++; bad++;
      $display("FAIL frame_timeout: got no done expected done within 3000 cycles");
    end
    repeat (5) @(negedge clk);
    check("single_done", done_cnt, d0 + 1);
    bp_en = 0; oor_en = 0;
  endtask

  initial begin
    int t;
    rst = 1; start = 0; angle = 0; frame_active = 0; bp_en = 0; oor_en = 0;
    stub_lat = 3; bp_left = 0; exp_angle = 0;
    repeat (3) @(negedge clk);
    #1;
    check("reset_outputs", {busy, done, rot_start, rot_h, rot_v, rot_angle, sram_rd, sram_addr,
                            pix_valid, pix_h, pix_v, pix_data}, 0);
    @(negedge clk); rst = 0;

    run_frame(9'sd0, 3, 0, 0, 0);
    run_frame(9'sd0, 2, 1, 0, 0);
    run_frame(9'sd0, 1, 0, 1, 0);
    run_frame(9'sd90, 2, 0, 0, 1);

    // reset while waiting for the rotation result; its valid arrives a cycle later
    stub_lat = 3; exp_angle = 9'sd30;
    @(negedge clk); angle = 9'sd30; start = 1;
    @(negedge clk); start = 0; frame_active = 1;
    t = 0;
    while (!rot_start && t < 100) begin @(negedge clk); t++; end
    check("launch_seen", rot_start, 1);
    @(negedge clk);
    @(negedge clk); rst = 1; frame_active = 0;
    @(negedge clk); rst = 0;
    #1;
    check("rot_valid_after_reset", rot_valid, 1);
    check("midframe_reset_outputs", {busy, done, rot_start, rot_h, rot_v, rot_angle, sram_rd,
                                     sram_addr, pix_valid, pix_h, pix_v, pix_data}, 0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); #1;
      check("idle_after_reset", {sram_rd, pix_valid, busy, rot_start}, 0);
    end

    @(negedge clk); rst = 1; start = 1; angle = 9'sd20;
    @(negedge clk); rst = 0; start = 0;
    #1;
    check("rst_start_idle", {busy, rot_start}, 0);
    run_frame(9'sd20, 3, 0, 0, 0);

    check("scoreboard_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
